// File: rtl/clint_access_arbiter.sv
// -----------------------------------------------------------------------------
// clint_access_arbiter
//
// Purpose:
//   Shares the single CLINT register-access port among NR_REQ requesters with
//   round-robin fairness. Every access runs grant -> access -> response:
//     cycle t   : gnt_o[w] pulses, the requester payload is latched
//     cycle t+1 : en_o is high and the latched payload drives the CLINT port
//     cycle t+2 : rvalid_o[w] pulses with rdata_o (0 for writes)
//   A new grant may fire in the response cycle, giving 1 access per 2 cycles.
//
// Handshake:
//   req_i[n] is a level request. The requester holds it (and its payload)
//   until it sees gnt_o[n]. It may change both from the following cycle,
//   because the arbiter works only from its latched copy. Dropping req_i
//   before the grant withdraws the request with no access and no response.
//   gnt_o and rvalid_o are one-hot single-cycle strobes. There is no
//   back-pressure on the response.
//
// Configuration:
//   CLINT_ARB_LOCK_EN - when defined, lock_i[w]=1 on a grant makes w the only
//   eligible requester until it is granted again with lock_i=0, or until it
//   stays silent for LOCK_TIMEOUT consecutive IDLE cycles. Without the macro,
//   lock_i is ignored.
//
// Ports:
//   clk_i, rst_ni          clock, asynchronous active-low reset
//   req_i/we_i/lock_i      per-requester request, write flag, lock request
//   addr_i/be_i/wdata_i    per-requester packed payload
//   gnt_o/rvalid_o/rdata_o per-requester grant, response strobe, read data
//   en_o/we_o/address_o/be_o/wdata_o/rdata_i   CLINT register port
// -----------------------------------------------------------------------------
module clint_access_arbiter #(
  parameter int NR_REQ       = 2,
  parameter int ADDR_WIDTH   = 64,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic [NR_REQ-1:0]            req_i,
  input  logic [NR_REQ-1:0]            we_i,
  input  logic [NR_REQ*ADDR_WIDTH-1:0] addr_i,
  input  logic [NR_REQ*8-1:0]          be_i,
  input  logic [NR_REQ*64-1:0]         wdata_i,
  input  logic [NR_REQ-1:0]            lock_i,
  output logic [NR_REQ-1:0]            gnt_o,
  output logic [NR_REQ-1:0]            rvalid_o,
  output logic [63:0]                  rdata_o,
  output logic                         en_o,
  output logic                         we_o,
  output logic [ADDR_WIDTH-1:0]        address_o,
  output logic [7:0]                   be_o,
  output logic [63:0]                  wdata_o,
  input  logic [63:0]                  rdata_i
);

  localparam int IW = (NR_REQ > 1) ? $clog2(NR_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [IW-1:0]           r_last;
  logic [IW-1:0]           r_winner;
  logic                    r_we;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [7:0]              r_be;
  logic [63:0]             r_wdata;
  logic [63:0]             r_rdata;

  logic [NR_REQ-1:0]       w_elig;
  logic [IW-1:0]           w_pick;
  logic [IW-1:0]           w_idx;
  logic                    w_found;
  logic                    w_fire;

  // ---------------------------------------------------------------------------
  // Eligibility: with the lock held only the owner may be granted.
  // ---------------------------------------------------------------------------
`ifdef CLINT_ARB_LOCK_EN
  localparam int CW = $clog2(LOCK_TIMEOUT + 1);

  logic          r_lock;
  logic [IW-1:0] r_owner;
  logic [CW-1:0] r_lock_cnt;

  always_comb begin
    w_elig = req_i;
    if (r_lock) begin
      w_elig          = '0;
      w_elig[r_owner] = req_i[r_owner];
    end
  end

  // A grant (always the owner while locked) reloads the lock from lock_i.
  // Silent IDLE cycles of the owner count towards the forced release.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_lock     <= 1'b0;
      r_owner    <= '0;
      r_lock_cnt <= '0;
    end else if (w_fire) begin
      r_lock     <= lock_i[w_pick];
      r_owner    <= w_pick;
      r_lock_cnt <= '0;
    end else if (r_lock && (r_state == S_IDLE) && !req_i[r_owner]) begin
      if (r_lock_cnt == CW'(LOCK_TIMEOUT - 1)) begin
        r_lock     <= 1'b0;
        r_lock_cnt <= '0;
      end else begin
        r_lock_cnt <= r_lock_cnt + CW'(1);
      end
    end else begin
      r_lock_cnt <= '0;
    end
  end
`else
  logic w_unused_cfg;

  assign w_elig       = req_i;
  assign w_unused_cfg = ^{lock_i, 32'(LOCK_TIMEOUT)};
`endif

  // ---------------------------------------------------------------------------
  // Round-robin pick: first eligible requester after r_last, with wrap.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_found = 1'b0;
    w_pick  = '0;
    w_idx   = '0;
    for (int i = 1; i <= NR_REQ; i++) begin
      w_idx = IW'((int'(r_last) + i) % NR_REQ);
      if (!w_found && w_elig[w_idx]) begin
        w_found = 1'b1;
        w_pick  = w_idx;
      end
    end
  end

  // Grants are issued from IDLE and also from RESP (overlapping response).
  assign w_fire = ((r_state == S_IDLE) || (r_state == S_RESP)) && w_found;

  // ---------------------------------------------------------------------------
  // FSM: state register / next state / outputs
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:   w_state_nxt = w_fire ? S_ACCESS : S_IDLE;
      S_ACCESS: w_state_nxt = S_RESP;
      S_RESP:   w_state_nxt = w_fire ? S_ACCESS : S_IDLE;
      default:  w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    gnt_o     = '0;
    rvalid_o  = '0;
    rdata_o   = '0;
    en_o      = 1'b0;
    we_o      = 1'b0;
    address_o = '0;
    be_o      = '0;
    wdata_o   = '0;
    // Grant is combinational from req_i; masking with rst_ni keeps it quiet
    // while reset is held.
    if (w_fire && rst_ni) begin
      gnt_o[w_pick] = 1'b1;
    end
    if (r_state == S_ACCESS) begin
      en_o      = 1'b1;
      we_o      = r_we;
      address_o = r_addr;
      be_o      = r_be;
      wdata_o   = r_wdata;
    end
    if (r_state == S_RESP) begin
      rvalid_o[r_winner] = 1'b1;
      rdata_o            = r_rdata;
    end
  end

  // ---------------------------------------------------------------------------
  // Payload latch and read-data capture
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_last   <= IW'(NR_REQ - 1);
      r_winner <= '0;
      r_we     <= 1'b0;
      r_addr   <= '0;
      r_be     <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
    end else begin
      if (w_fire) begin
        r_last   <= w_pick;
        r_winner <= w_pick;
        r_we     <= we_i[w_pick];
        r_addr   <= addr_i[w_pick*ADDR_WIDTH +: ADDR_WIDTH];
        r_be     <= be_i[w_pick*8 +: 8];
        r_wdata  <= wdata_i[w_pick*64 +: 64];
      end
      if (r_state == S_ACCESS) begin
        r_rdata <= r_we ? 64'd0 : rdata_i;
      end
    end
  end

endmodule

// File: tb/tb_clint_access_arbiter.sv
// -----------------------------------------------------------------------------
// tb_clint_access_arbiter
//
// Bench for clint_access_arbiter (NR_REQ=2, ADDR_WIDTH=64). Inputs are driven
// on the falling edge, outputs are sampled 1 time unit later. A small CLINT
// model answers reads combinationally from address_o. Expected responses are
// queued when the request is driven and popped in the response cycle.
// Lock expectations follow CLINT_ARB_LOCK_EN.
// -----------------------------------------------------------------------------
module tb_clint_access_arbiter;

  // clock / reset
  logic clk = 1'b0;
  logic rst_ni;
  always #5 clk = ~clk;

  // DUT signals
  logic [1:0]   req_i, we_i, lock_i;
  logic [63:0]  a0, a1, wd0, wd1;
  logic [7:0]   be0, be1;
  logic [1:0]   gnt_o, rvalid_o;
  logic [63:0]  rdata_o, address_o, wdata_o, rdata_i;
  logic         en_o, we_o;
  logic [7:0]   be_o;

  int errors = 0;
  int checks = 0;
  logic [65:0] exp_q[$];
  logic [65:0] exp_v;

  function automatic logic [63:0] clint_model(input logic [63:0] a);
    if (a == 64'hBFF8) return 64'h1234;
    return {a[31:0] ^ 32'hDEAD_BEEF, ~a[31:0]};
  endfunction

  assign rdata_i = clint_model(address_o);

  clint_access_arbiter #(.NR_REQ(2), .ADDR_WIDTH(64), .LOCK_TIMEOUT(16)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_ni),
    .req_i     (req_i),
    .we_i      (we_i),
    .addr_i    ({a1, a0}),
    .be_i      ({be1, be0}),
    .wdata_i   ({wd1, wd0}),
    .lock_i    (lock_i),
    .gnt_o     (gnt_o),
    .rvalid_o  (rvalid_o),
    .rdata_o   (rdata_o),
    .en_o      (en_o),
    .we_o      (we_o),
    .address_o (address_o),
    .be_o      (be_o),
    .wdata_o   (wdata_o),
    .rdata_i   (rdata_i)
  );

  // driver helpers
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic do_reset();
    tick();
    rst_ni = 1'b0;
    req_i  = 2'b00;
    lock_i = 2'b00;
    tick();
    tick();
    rst_ni = 1'b1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    rst_ni = 1'b0;
    req_i  = 2'b01;
    a0     = 64'hBFF8;
    tick();
    tick();
    #1;
    checks++; if (gnt_o !== 2'b00) begin errors++; $display("FAIL reset_gnt: gnt_o=%b required 00", gnt_o); end
    checks++; if ({en_o, we_o, be_o} !== 10'd0) begin errors++; $display("FAIL reset_port: en=%b we=%b be=%h required 0", en_o, we_o, be_o); end
    checks++; if ({address_o, wdata_o} !== 128'd0) begin errors++; $display("FAIL reset_addr_wdata: address_o=%h wdata_o=%h required 0", address_o, wdata_o); end
    checks++; if ({rvalid_o, rdata_o} !== 66'd0) begin errors++; $display("FAIL reset_resp: rvalid_o=%b rdata_o=%h required 0", rvalid_o, rdata_o); end
    tick();
    req_i  = 2'b00;
    rst_ni = 1'b1;
    tick();
    #1;
    checks++; if ({gnt_o, en_o} !== 3'd0) begin errors++; $display("FAIL idle_quiet: gnt_o=%b en_o=%b required 0", gnt_o, en_o); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_single_read();
    tick();
    req_i = 2'b01; we_i = 2'b00; a0 = 64'hBFF8; be0 = 8'hFF;
    exp_q.push_back({2'b01, 64'h1234});
    #1;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL read_gnt: gnt_o=%b required 01", gnt_o); end
    tick();
    req_i = 2'b00; a0 = 64'hDEAD_0000;  // payload changes after grant
    #1;
    checks++; if ({en_o, we_o} !== 2'b10) begin errors++; $display("FAIL read_en: en_o=%b we_o=%b required 1 0", en_o, we_o); end
    checks++; if (address_o !== 64'hBFF8) begin errors++; $display("FAIL read_addr: address_o=%h required bff8", address_o); end
    checks++; if (be_o !== 8'hFF) begin errors++; $display("FAIL read_be: be_o=%h required ff", be_o); end
    checks++; if ({gnt_o, rvalid_o} !== 4'd0) begin errors++; $display("FAIL read_access_quiet: gnt_o=%b rvalid_o=%b required 0", gnt_o, rvalid_o); end
    tick();
    #1;
    exp_v = exp_q.pop_front();
    checks++; if ({rvalid_o, rdata_o} !== exp_v) begin errors++; $display("FAIL read_resp: rvalid/rdata=%h required %h", {rvalid_o, rdata_o}, exp_v); end
    checks++; if ({en_o, address_o} !== 65'd0) begin errors++; $display("FAIL read_resp_port: en_o=%b address_o=%h required 0", en_o, address_o); end
    tick();
    #1;
    checks++; if ({rvalid_o, rdata_o} !== 66'd0) begin errors++; $display("FAIL read_after: rvalid_o=%b rdata_o=%h required 0", rvalid_o, rdata_o); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_write();
    tick();
    req_i = 2'b10; we_i = 2'b10; a1 = 64'h4000; wd1 = 64'hFF; be1 = 8'hFF;
    exp_q.push_back({2'b10, 64'h0});
    #1;
    checks++; if (gnt_o !== 2'b10) begin errors++; $display("FAIL write_gnt: gnt_o=%b required 10", gnt_o); end
    tick();
    req_i = 2'b00; wd1 = 64'h55;
    #1;
    checks++; if ({en_o, we_o} !== 2'b11) begin errors++; $display("FAIL write_en: en_o=%b we_o=%b required 1 1", en_o, we_o); end
    checks++; if (address_o !== 64'h4000) begin errors++; $display("FAIL write_addr: address_o=%h required 4000", address_o); end
    checks++; if ({wdata_o, be_o} !== {64'hFF, 8'hFF}) begin errors++; $display("FAIL write_data: wdata_o=%h be_o=%h required ff ff", wdata_o, be_o); end
    tick();
    #1;
    exp_v = exp_q.pop_front();
    checks++; if ({rvalid_o, rdata_o} !== exp_v) begin errors++; $display("FAIL write_resp: rvalid/rdata=%h required %h", {rvalid_o, rdata_o}, exp_v); end
    we_i = 2'b00;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_back_to_back();
    logic [1:0]  exp_g;
    logic [63:0] exp_a;
    do_reset();
    a0 = 64'h100; a1 = 64'h200; we_i = 2'b00;
    exp_q.push_back({2'b01, clint_model(64'h100)});
    exp_q.push_back({2'b10, clint_model(64'h200)});
    exp_q.push_back({2'b01, clint_model(64'h100)});
    exp_q.push_back({2'b10, clint_model(64'h200)});
    for (int k = 0; k < 9; k++) begin
      tick();
      if (k == 0) req_i = 2'b11;
      if (k == 7) req_i = 2'b00;
      #1;
      exp_g = (k <= 6 && (k % 2) == 0) ? (((k % 4) == 0) ? 2'b01 : 2'b10) : 2'b00;
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL b2b_gnt[%0d]: gnt_o=%b required %b", k, gnt_o, exp_g); end
      if (k >= 2 && (k % 2) == 0) begin
        exp_v = exp_q.pop_front();
        checks++; if ({rvalid_o, rdata_o} !== exp_v) begin errors++; $display("FAIL b2b_resp[%0d]: rvalid/rdata=%h required %h", k, {rvalid_o, rdata_o}, exp_v); end
      end else begin
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL b2b_quiet[%0d]: rvalid_o=%b required 00", k, rvalid_o); end
      end
      if ((k % 2) == 1) begin
        exp_a = ((k % 4) == 1) ? 64'h100 : 64'h200;
        checks++; if ({en_o, address_o} !== {1'b1, exp_a}) begin errors++; $display("FAIL b2b_access[%0d]: en_o=%b address_o=%h required 1 %h", k, en_o, address_o, exp_a); end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset_mid_access();
    tick();
    req_i = 2'b01; a0 = 64'h300;
    #1;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rst_mid_gnt: gnt_o=%b required 01", gnt_o); end
    tick();
    req_i = 2'b00;
    #1;
    checks++; if (en_o !== 1'b1) begin errors++; $display("FAIL rst_mid_en: en_o=%b required 1", en_o); end
    #2;
    rst_ni = 1'b0;
    #1;
    checks++; if ({en_o, we_o, be_o, gnt_o, rvalid_o} !== 14'd0) begin errors++; $display("FAIL rst_mid_ctrl: en=%b we=%b be=%h gnt=%b rvalid=%b required 0", en_o, we_o, be_o, gnt_o, rvalid_o); end
    checks++; if ({address_o, rdata_o} !== 128'd0) begin errors++; $display("FAIL rst_mid_data: address_o=%h rdata_o=%h required 0", address_o, rdata_o); end
    tick();
    tick();
    rst_ni = 1'b1;
    for (int k = 0; k < 3; k++) begin
      tick();
      #1;
      checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL rst_mid_no_resp[%0d]: rvalid_o=%b required 00", k, rvalid_o); end
    end
    tick();
    req_i = 2'b11; a1 = 64'h400;
    exp_q.push_back({2'b01, clint_model(64'h300)});
    #1;
    checks++; if (gnt_o !== 2'b01) begin errors++; $display("FAIL rst_mid_next_gnt: gnt_o=%b required 01", gnt_o); end
    tick();
    req_i = 2'b00;
    tick();
    #1;
    exp_v = exp_q.pop_front();
    checks++; if ({rvalid_o, rdata_o} !== exp_v) begin errors++; $display("FAIL rst_mid_resp: rvalid/rdata=%h required %h", {rvalid_o, rdata_o}, exp_v); end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lock();
    logic [1:0] pr [0:4];
    logic [1:0] pg [0:4];
    logic [1:0] exp_g;
    do_reset();
    a0 = 64'hBFF8; a1 = 64'h20; we_i = 2'b00;
`ifdef CLINT_ARB_LOCK_EN
    pr = '{2'b11, 2'b11, 2'b11, 2'b10, 2'b10};
    pg = '{2'b01, 2'b00, 2'b01, 2'b00, 2'b10};
    exp_q.push_back({2'b01, 64'h1234});
    exp_q.push_back({2'b01, clint_model(64'hBFFC)});
    exp_q.push_back({2'b10, clint_model(64'h20)});
`else
    pr = '{2'b11, 2'b11, 2'b11, 2'b01, 2'b01};
    pg = '{2'b01, 2'b00, 2'b10, 2'b00, 2'b01};
    exp_q.push_back({2'b01, 64'h1234});
    exp_q.push_back({2'b10, clint_model(64'h20)});
    exp_q.push_back({2'b01, clint_model(64'hBFFC)});
`endif
    for (int k = 0; k < 7; k++) begin
      tick();
      req_i = (k < 5) ? pr[k] : 2'b00;
      if (k == 0) lock_i = 2'b01;
      if (k == 1) begin a0 = 64'hBFFC; lock_i = 2'b00; end
      #1;
      exp_g = (k < 5) ? pg[k] : 2'b00;
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL lock_gnt[%0d]: gnt_o=%b required %b", k, gnt_o, exp_g); end
      if (k == 2 || k == 4 || k == 6) begin
        exp_v = exp_q.pop_front();
        checks++; if ({rvalid_o, rdata_o} !== exp_v) begin errors++; $display("FAIL lock_resp[%0d]: rvalid/rdata=%h required %h", k, {rvalid_o, rdata_o}, exp_v); end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_lock_timeout();
    int         g;
    logic [1:0] exp_g;
`ifdef CLINT_ARB_LOCK_EN
    g = 19;
`else
    g = 2;
`endif
    do_reset();
    a0 = 64'hBFF8; a1 = 64'h20; we_i = 2'b00;
    for (int k = 0; k < 25; k++) begin
      tick();
      if (k == 0) begin
        req_i = 2'b01; lock_i = 2'b01;
        exp_q.push_back({2'b01, 64'h1234});
        exp_q.push_back({2'b10, clint_model(64'h20)});
      end
      if (k == 1) begin req_i = 2'b10; lock_i = 2'b00; end
      if (k == g + 1) req_i = 2'b00;
      #1;
      exp_g = (k == 0) ? 2'b01 : ((k == g) ? 2'b10 : 2'b00);
      checks++; if (gnt_o !== exp_g) begin errors++; $display("FAIL timeout_gnt[%0d]: gnt_o=%b required %b", k, gnt_o, exp_g); end
      if (k == 2 || k == g + 2) begin
        exp_v = exp_q.pop_front();
        checks++; if ({rvalid_o, rdata_o} !== exp_v) begin errors++; $display("FAIL timeout_resp[%0d]: rvalid/rdata=%h required %h", k, {rvalid_o, rdata_o}, exp_v); end
      end else begin
        checks++; if (rvalid_o !== 2'b00) begin errors++; $display("FAIL timeout_quiet[%0d]: rvalid_o=%b required 00", k, rvalid_o); end
      end
    end
  endtask

  // ---------------------------------------------------------------------------
  initial begin
    rst_ni = 1'b0; req_i = 2'b00; we_i = 2'b00; lock_i = 2'b00;
    a0 = '0; a1 = '0; wd0 = '0; wd1 = '0; be0 = '0; be1 = '0;
    wd0 = 64'($urandom_range(0, 32'hFFFF));
    test_reset();
    test_single_read();
    test_write();
    test_back_to_back();
    test_reset_mid_access();
    test_lock();
    test_lock_timeout();
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL scoreboard_drain: %0d responses outstanding, required 0", exp_q.size()); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
